// File: rtl/game_pkg.sv
// Shared game types and constants: knockback state encoding, screen geometry and
// the velocity decay helper used by the launch controller.
package game_pkg;

  typedef enum logic [1:0] {
    KB_IDLE   = 2'd0,
    KB_LAUNCH = 2'd1,
    KB_DECAY  = 2'd2
  } kb_state_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // One px/frame step toward zero; zero stays zero so there is never an overshoot.
  function automatic logic signed [5:0] step_toward_zero(input logic signed [5:0] v);
    logic signed [5:0] r;
    if (v > 6'sd0) begin
      r = v - 6'sd1;
    end else if (v < 6'sd0) begin
      r = v + 6'sd1;
    end else begin
      r = 6'sd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/knockback_fsm.sv
// Per-player launch controller: latches a damage-scaled knockback on a hit, emits a
// decaying velocity once per frame while holding the controls locked, and flags KOs.
module knockback_fsm
  import game_pkg::*;
#(
  parameter int unsigned BASE_KB  = 2,
  parameter int unsigned KB_SHIFT = 4,
  parameter int unsigned MAX_KB   = 15,
  parameter int unsigned BLAST_X  = SCREEN_W,
  parameter int unsigned BLAST_Y  = SCREEN_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              got_hit,
  input  logic              hit_from_left,
  input  logic [9:0]        damage,
  input  logic [9:0]        x_pos,
  input  logic [9:0]        y_pos,
  output logic signed [5:0] vx,
  output logic signed [5:0] vy,
  output logic              lock_controls,
  output logic              ko
);

  localparam logic [9:0]  BLAST_X_C = 10'(BLAST_X);
  localparam logic [9:0]  BLAST_Y_C = 10'(BLAST_Y);
  localparam logic [10:0] BASE_KB_C = 11'(BASE_KB);
  localparam logic [10:0] MAX_KB_C  = 11'(MAX_KB);

  kb_state_t         state_r, state_nxt_s;
  logic [4:0]        mag_r, mag_nxt_s, mag_s;
  logic              dir_r, dir_nxt_s;
  logic signed [5:0] vx_r, vy_r, vx_nxt_s, vy_nxt_s;
  logic              ko_r, ko_nxt_s;
  logic              lock_r;
  logic [10:0]       kb_sum_s;
  logic signed [5:0] mag_sv_s;
  logic              off_stage_s;
  logic signed [5:0] vx_dec_s, vy_dec_s;

  // Damage-scaled magnitude, widened to 11 bits so damage=1023 cannot wrap before the clamp.
  always_comb begin
    kb_sum_s = BASE_KB_C + {1'b0, (damage >> KB_SHIFT)};
    if (kb_sum_s > MAX_KB_C) begin
      mag_s = MAX_KB_C[4:0];
    end else begin
      mag_s = kb_sum_s[4:0];
    end
  end

  assign mag_sv_s    = $signed({1'b0, mag_r});
  assign off_stage_s = (x_pos >= BLAST_X_C) || (y_pos >= BLAST_Y_C);
  assign vx_dec_s    = step_toward_zero(vx_r);
  assign vy_dec_s    = step_toward_zero(vy_r);

  // Next-state and next-output logic; a hit outranks a same-cycle frame tick.
  always_comb begin
    state_nxt_s = state_r;
    mag_nxt_s   = mag_r;
    dir_nxt_s   = dir_r;
    vx_nxt_s    = vx_r;
    vy_nxt_s    = vy_r;
    ko_nxt_s    = 1'b0;
    if (got_hit) begin
      state_nxt_s = KB_LAUNCH;
      mag_nxt_s   = mag_s;
      dir_nxt_s   = hit_from_left;
    end else if (frame_tick) begin
      case (state_r)
        KB_IDLE: begin
          vx_nxt_s = 6'sd0;
          vy_nxt_s = 6'sd0;
        end
        KB_LAUNCH: begin
          vx_nxt_s    = dir_r ? mag_sv_s : -mag_sv_s;
          vy_nxt_s    = -mag_sv_s;
          state_nxt_s = KB_DECAY;
        end
        KB_DECAY: begin
          if (off_stage_s) begin
            ko_nxt_s    = 1'b1;
            vx_nxt_s    = 6'sd0;
            vy_nxt_s    = 6'sd0;
            state_nxt_s = KB_IDLE;
          end else begin
            vx_nxt_s = vx_dec_s;
            vy_nxt_s = vy_dec_s;
            if ((vx_dec_s == 6'sd0) && (vy_dec_s == 6'sd0)) begin
              state_nxt_s = KB_IDLE;
            end else begin
              state_nxt_s = KB_DECAY;
            end
          end
        end
        default: begin
          state_nxt_s = KB_IDLE;
          vx_nxt_s    = 6'sd0;
          vy_nxt_s    = 6'sd0;
        end
      endcase
    end else begin
      ko_nxt_s = 1'b0;
    end
  end

  // State and output registers; lock follows the next state so it aligns with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= KB_IDLE;
      mag_r   <= 5'd0;
      dir_r   <= 1'b0;
      vx_r    <= 6'sd0;
      vy_r    <= 6'sd0;
      ko_r    <= 1'b0;
      lock_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      mag_r   <= mag_nxt_s;
      dir_r   <= dir_nxt_s;
      vx_r    <= vx_nxt_s;
      vy_r    <= vy_nxt_s;
      ko_r    <= ko_nxt_s;
      lock_r  <= (state_nxt_s != KB_IDLE);
    end
  end

  assign vx            = vx_r;
  assign vy            = vy_r;
  assign lock_controls = lock_r;
  assign ko            = ko_r;

endmodule

// File: tb/tb_knockback_fsm.sv
// Scoreboard bench for knockback_fsm: a driver pushes per-cycle expectations from a
// behavioural launch model; a monitor pops and compares them after each clock edge.
module tb_knockback_fsm;

  localparam int BASE = 2;
  localparam int DIV  = 16;
  localparam int CAP  = 15;
  localparam int BX   = 640;
  localparam int BY   = 480;

  logic              clk = 1'b0;
  logic              reset, frame_tick, got_hit, hit_from_left;
  logic [9:0]        damage, x_pos, y_pos;
  logic signed [5:0] vx, vy;
  logic              lock_controls, ko;

  typedef struct packed {
    logic signed [5:0] vx;
    logic signed [5:0] vy;
    logic              lock;
    logic              ko;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_n;
  string cur_test = "init";
  int    checks = 0;
  int    errors = 0;

  // Launch model: 'armed' waits for the first tick, 'flying' decays each tick.
  bit armed, flying, m_dir, m_ko;
  int m_mag, m_vx, m_vy;

  knockback_fsm dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .got_hit(got_hit),
    .hit_from_left(hit_from_left), .damage(damage), .x_pos(x_pos), .y_pos(y_pos),
    .vx(vx), .vy(vy), .lock_controls(lock_controls), .ko(ko)
  );

  always #5 clk = ~clk;

  function automatic int toward_zero(input int v);
    if (v > 0) return v - 1;
    if (v < 0) return v + 1;
    return 0;
  endfunction

  task automatic model(input bit rst, input bit hit, input bit left, input bit tick,
                       input int dmg, input int xp, input int yp);
    m_ko = 1'b0;
    if (rst) begin
      armed = 0; flying = 0; m_dir = 0; m_mag = 0; m_vx = 0; m_vy = 0;
    end else if (hit) begin
      m_mag = BASE + dmg / DIV;
      if (m_mag > CAP) m_mag = CAP;
      m_dir = left;
      armed = 1;
      flying = 0;
    end else if (tick) begin
      if (armed) begin
        m_vx = m_dir ? m_mag : -m_mag;
        m_vy = -m_mag;
        armed = 0;
        flying = 1;
      end else if (flying) begin
        if (xp >= BX || yp >= BY) begin
          m_ko = 1; m_vx = 0; m_vy = 0; flying = 0;
        end else begin
          m_vx = toward_zero(m_vx);
          m_vy = toward_zero(m_vy);
          if (m_vx == 0 && m_vy == 0) flying = 0;
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit hit, input bit left, input bit tick,
                      input int dmg, input int xp, input int yp);
    exp_t e;
    reset = rst; got_hit = hit; hit_from_left = left; frame_tick = tick;
    damage = 10'(dmg); x_pos = 10'(xp); y_pos = 10'(yp);
    model(rst, hit, left, tick, dmg, xp, yp);
    e.vx = 6'(m_vx); e.vy = 6'(m_vy); e.lock = armed | flying; e.ko = m_ko;
    exp_q.push_back(e);
    name_q.push_back(cur_test);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 100, 100);
  endtask

  task automatic tick(input int xp, input int yp);
    step(0, 0, 0, 1, 0, xp, yp);
    idle(2);
  endtask

  task automatic hit(input int dmg, input bit left);
    step(0, 1, left, 0, dmg, 100, 100);
    idle(1);
  endtask

  // Monitor: one expectation per clock edge, compared 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        checks++;
        if (vx !== mon_e.vx || vy !== mon_e.vy || lock_controls !== mon_e.lock || ko !== mon_e.ko) begin
          errors++;
          $display("FAIL %s @%0t: got vx=%0d vy=%0d lock=%b ko=%b, expected vx=%0d vy=%0d lock=%b ko=%b",
                   mon_n, $time, vx, vy, lock_controls, ko, mon_e.vx, mon_e.vy, mon_e.lock, mon_e.ko);
        end
      end
    end
  end

  initial begin
    cur_test = "reset";
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 100, 100);
    idle(2);

    cur_test = "launch_48_right";
    hit(48, 1);
    for (int i = 0; i < 7; i++) tick(100, 100);

    cur_test = "launch_600_saturate";
    hit(600, 0);
    for (int i = 0; i < 17; i++) tick(200, 300);

    cur_test = "launch_1023_and_0";
    hit(1023, 1);
    tick(100, 100);
    hit(0, 0);
    for (int i = 0; i < 4; i++) tick(100, 100);

    cur_test = "ko_offstage_x";
    hit(16, 1);
    tick(100, 100);
    tick(650, 100);
    tick(650, 100);

    cur_test = "ko_offstage_y_wrap";
    hit(200, 0);
    tick(100, 100);
    tick(100, 1000);

    cur_test = "no_ko_in_launch";
    hit(100, 1);
    tick(700, 500);
    for (int i = 0; i < 9; i++) tick(100, 100);

    cur_test = "hit_and_tick_same_cycle";
    hit(64, 1);
    tick(100, 100); tick(100, 100); tick(100, 100);
    step(0, 1, 1, 1, 16, 700, 100);
    idle(2);
    for (int i = 0; i < 5; i++) tick(100, 100);

    cur_test = "restart_in_decay";
    hit(160, 0);
    tick(100, 100); tick(100, 100);
    hit(32, 1);
    for (int i = 0; i < 6; i++) tick(100, 100);

    cur_test = "reset_mid_decay";
    hit(80, 0);
    tick(100, 100);
    step(1, 0, 0, 1, 0, 700, 100);
    idle(2);
    tick(700, 100);

    cur_test = "random";
    for (int i = 0; i < 3000; i++) begin
      bit r_rst, r_hit, r_tick;
      int xp, yp;
      r_rst  = ($urandom_range(299, 0) == 0);
      r_hit  = ($urandom_range(24, 0) == 0);
      r_tick = ($urandom_range(3, 0) == 0);
      xp = ($urandom_range(15, 0) == 0) ? $urandom_range(1023, 640) : $urandom_range(639, 0);
      yp = ($urandom_range(15, 0) == 0) ? $urandom_range(1023, 480) : $urandom_range(479, 0);
      step(r_rst, r_hit, 1'($urandom_range(1, 0)), r_tick, $urandom_range(1023, 0), xp, yp);
    end

    cur_test = "drain";
    idle(3);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
